// File: rtl/inv_status_pkg.sv
// Shared types and constants for the inverter status scanner.
package inv_status_pkg;

  localparam int DEF_N_CH     = 8;
  localparam int DEF_STATUS_W = 4;
  localparam int SETTLE_W     = 8;

  // Bit positions inside one channel's status word.
  localparam int FAULT_BIT = 0;
  localparam int READY_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_SAMPLE  = 2'd2,
    ST_ADVANCE = 2'd3
  } scan_state_e;

endpackage

// File: rtl/inv_status_settle_timer.sv
// Mux settle down-counter: loads a cycle count, then counts down and
// holds at zero; expired flags the zero terminal count.
module inv_status_settle_timer
  import inv_status_pkg::*;
(
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] value,
  output logic                expired
);

  logic [SETTLE_W-1:0] cnt_q;

  // Load wins; otherwise decrement until the terminal count is reached.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/inv_status_scanner.sv
// Round-robin scanner of inverter channel status through an external mux.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | not scanning, ch_sel parked at 0, snapshot retained
//   SETTLE  | waiting for the status mux output to settle
//   SAMPLE  | capture status_in for ch_sel, latch fault (clear blocked)
//   ADVANCE | step to next channel, or wrap and signal scan_done
module inv_status_scanner
  import inv_status_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int STATUS_W = DEF_STATUS_W
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       enable,
  input  logic [SETTLE_W-1:0]        settle_cycles,
  output logic [$clog2(N_CH)-1:0]    ch_sel,
  input  logic [STATUS_W-1:0]        status_in,
  output logic [N_CH*STATUS_W-1:0]   status_out,
  output logic [N_CH-1:0]            fault_sticky,
  input  logic                       clr_valid,
  input  logic [N_CH-1:0]            clr_mask,
  output logic                       clr_ready,
  output logic                       scan_done,
  output logic                       irq
);

  localparam int                CH_W    = $clog2(N_CH);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);

  scan_state_e                state_q, state_d;
  logic [CH_W-1:0]            ch_sel_q, ch_sel_d;
  logic [N_CH*STATUS_W-1:0]   status_q, status_d;
  logic [N_CH-1:0]            fault_q, fault_d;
  logic [N_CH-1:0]            fault_set, fault_clr;
  logic                       done_q, done_d;
  logic                       irq_q;
  logic                       timer_load;
  logic                       timer_expired;

  inv_status_settle_timer u_settle_timer (
    .clk_sys (ACLK),
    .rst_n   (ARESETN),
    .load    (timer_load),
    .value   (settle_cycles),
    .expired (timer_expired)
  );

  // Next-state, channel stepping and timer reload.
  always_comb begin
    state_d    = state_q;
    ch_sel_d   = ch_sel_q;
    done_d     = 1'b0;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_SETTLE;
          timer_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_expired) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (ch_sel_q == LAST_CH) begin
          ch_sel_d = '0;
          done_d   = 1'b1;
          if (enable) begin
            state_d    = ST_SETTLE;
            timer_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ch_sel_d   = ch_sel_q + 1'b1;
          state_d    = ST_SETTLE;
          timer_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Snapshot capture and sticky fault update; a set outranks a clear.
  always_comb begin
    status_d  = status_q;
    fault_set = '0;
    fault_clr = '0;
    if (state_q == ST_SAMPLE) begin
      status_d[int'(ch_sel_q)*STATUS_W +: STATUS_W] = status_in;
      if (status_in[FAULT_BIT]) fault_set[ch_sel_q] = 1'b1;
    end
    if (clr_valid && clr_ready) fault_clr = clr_mask;
    fault_d = (fault_q & ~fault_clr) | fault_set;
  end

  // State and datapath registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= ST_IDLE;
      ch_sel_q <= '0;
      status_q <= '0;
      fault_q  <= '0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_sel_q <= ch_sel_d;
      status_q <= status_d;
      fault_q  <= fault_d;
      done_q   <= done_d;
      irq_q    <= |fault_q;
    end
  end

  assign ch_sel       = ch_sel_q;
  assign status_out   = status_q;
  assign fault_sticky = fault_q;
  assign scan_done    = done_q;
  assign irq          = irq_q;
  assign clr_ready    = (state_q != ST_SAMPLE);

endmodule

// File: tb/tb_inv_status_scanner.sv
// Directed bench for inv_status_scanner (N_CH=8, STATUS_W=4).
module tb_inv_status_scanner;

  localparam int LIMIT = 2000;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        enable;
  logic [7:0]  settle_cycles;
  logic [2:0]  ch_sel;
  logic [3:0]  status_in;
  logic [31:0] status_out;
  logic [7:0]  fault_sticky;
  logic        clr_valid;
  logic [7:0]  clr_mask;
  logic        clr_ready;
  logic        scan_done;
  logic        irq;

  // External status mux model: faulting channels return flt_pat.
  logic [3:0]  ok_pat;
  logic [3:0]  flt_pat;
  logic [7:0]  flt_mask;

  int n_tests = 0;
  int n_fail  = 0;

  inv_status_scanner #(.N_CH(8), .STATUS_W(4)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .enable        (enable),
    .settle_cycles (settle_cycles),
    .ch_sel        (ch_sel),
    .status_in     (status_in),
    .status_out    (status_out),
    .fault_sticky  (fault_sticky),
    .clr_valid     (clr_valid),
    .clr_mask      (clr_mask),
    .clr_ready     (clr_ready),
    .scan_done     (scan_done),
    .irq           (irq)
  );

  always #5 ACLK = ~ACLK;

  always_comb status_in = flt_mask[ch_sel] ? flt_pat : ok_pat;

  typedef struct {
    logic [7:0]  settle;
    logic [3:0]  ok_pat;
    logic [3:0]  flt_pat;
    logic [7:0]  flt_mask;
    int          exp_period;
    int          exp_ch1;
    logic [31:0] exp_status;
    logic [7:0]  exp_fault;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, LIMIT);
  endtask

  // Cycles until the next scan_done pulse; also the cycle ch_sel first reads 1.
  task automatic wait_done(input string name, output int cycles, output int ch1_at);
    cycles = 0;
    ch1_at = -1;
    do begin
      @(negedge ACLK);
      cycles++;
      if (ch_sel == 3'd1 && ch1_at < 0) ch1_at = cycles;
    end while (!scan_done && cycles < LIMIT);
    if (!scan_done) timeout(name);
  endtask

  task automatic wait_ch(input string name, input logic [2:0] ch);
    int c;
    c = 0;
    do begin
      @(negedge ACLK);
      c++;
    end while (ch_sel != ch && c < LIMIT);
    if (ch_sel != ch) timeout(name);
  endtask

  task automatic wait_clr_ready(input string name);
    int c;
    c = 0;
    do begin
      @(negedge ACLK);
      c++;
    end while (!clr_ready && c < LIMIT);
    if (!clr_ready) timeout(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ch1, cnt, extra, bad;

    vecs[0] = '{8'd2, 4'h2, 4'h3, 8'h00, 40, 5, 32'h2222_2222, 8'h00, 1'b0};
    vecs[1] = '{8'd0, 4'h2, 4'h3, 8'h20, 24, 3, 32'h2232_2222, 8'h20, 1'b1};
    vecs[2] = '{8'd5, 4'hA, 4'hB, 8'h01, 64, 8, 32'hAAAA_AAAB, 8'h21, 1'b1};

    ARESETN = 1'b0;
    enable = 1'b0;
    settle_cycles = 8'd2;
    clr_valid = 1'b0;
    clr_mask = 8'h00;
    ok_pat = 4'h2;
    flt_pat = 4'h3;
    flt_mask = 8'h00;

    // Reset values.
    repeat (2) @(negedge ACLK);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_status_out", status_out, 0);
    check("rst_fault", fault_sticky, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_irq", irq, 0);
    check("rst_clr_ready", clr_ready, 1);
    ARESETN = 1'b1;
    repeat (4) @(negedge ACLK);
    check("idle_ch_sel", ch_sel, 0);
    check("idle_status_out", status_out, 0);

    // Full-scan vectors.
    enable = 1'b1;
    foreach (vecs[i]) begin
      settle_cycles = vecs[i].settle;
      ok_pat = vecs[i].ok_pat;
      flt_pat = vecs[i].flt_pat;
      flt_mask = vecs[i].flt_mask;
      wait_done($sformatf("v%0d_sync", i), cyc, ch1);
      wait_done($sformatf("v%0d_scan", i), cyc, ch1);
      check($sformatf("v%0d_period", i), cyc, vecs[i].exp_period);
      check($sformatf("v%0d_ch_step", i), ch1, vecs[i].exp_ch1);
      check($sformatf("v%0d_status_out", i), status_out, vecs[i].exp_status);
      check($sformatf("v%0d_fault", i), fault_sticky, vecs[i].exp_fault);
      check($sformatf("v%0d_irq", i), irq, vecs[i].exp_irq);
    end

    // Clear outside SAMPLE, one bit then the other; irq follows a cycle later.
    ok_pat = 4'h2;
    flt_mask = 8'h00;
    wait_clr_ready("clr1_wait");
    clr_valid = 1'b1;
    clr_mask = 8'h01;
    @(negedge ACLK);
    clr_valid = 1'b0;
    check("clr1_fault", fault_sticky, 8'h20);
    check("clr1_irq", irq, 1);
    wait_clr_ready("clr2_wait");
    clr_valid = 1'b1;
    clr_mask = 8'h20;
    @(negedge ACLK);
    clr_valid = 1'b0;
    check("clr2_fault", fault_sticky, 8'h00);
    check("clr2_irq_lag", irq, 1);
    @(negedge ACLK);
    check("clr2_irq", irq, 0);

    // Fault on ch5 only: irq lags the sticky set by one cycle; bit stays set.
    flt_pat = 4'h3;
    flt_mask = 8'h20;
    cnt = 0;
    do begin
      @(negedge ACLK);
      cnt++;
    end while (fault_sticky == 8'h00 && cnt < LIMIT);
    if (fault_sticky == 8'h00) timeout("set_wait");
    check("set_fault", fault_sticky, 8'h20);
    check("set_ch_sel", ch_sel, 5);
    check("set_irq_before", irq, 0);
    @(negedge ACLK);
    check("set_irq_after", irq, 1);
    flt_mask = 8'h00;
    wait_done("hold_a", cyc, ch1);
    wait_done("hold_b", cyc, ch1);
    check("set_hold", fault_sticky, 8'h20);

    // Clear held across SAMPLE of the faulting channel.
    flt_mask = 8'h20;
    wait_ch("coll_ch4", 3'd4);
    wait_ch("coll_ch5", 3'd5);
    clr_valid = 1'b1;
    clr_mask = 8'h20;
    cnt = 0;
    do begin
      @(negedge ACLK);
      cnt++;
    end while (clr_ready && cnt < LIMIT);
    if (clr_ready) timeout("coll_sample");
    check("coll_sample_ch", ch_sel, 5);
    @(negedge ACLK);
    check("coll_set_first", fault_sticky, 8'h20);
    check("coll_ready_back", clr_ready, 1);
    @(negedge ACLK);
    clr_valid = 1'b0;
    flt_mask = 8'h00;
    check("coll_cleared", fault_sticky, 8'h00);

    // settle_cycles=0, enable dropped at ch3: scan completes once, then IDLE.
    ok_pat = 4'h6;
    wait_done("drop_sync", cyc, ch1);
    settle_cycles = 8'd0;
    wait_ch("drop_ch3", 3'd3);
    enable = 1'b0;
    wait_ch("drop_ch4", 3'd4);
    cnt = 0;
    do begin
      @(negedge ACLK);
      cnt++;
    end while (ch_sel != 3'd5 && cnt < LIMIT);
    check("drop_ch_period", cnt, 3);
    wait_done("drop_done", cyc, ch1);
    check("drop_done_ch_sel", ch_sel, 0);
    ok_pat = 4'hF;
    extra = 0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge ACLK);
      if (scan_done) extra++;
      if (ch_sel != 3'd0) bad++;
    end
    check("drop_no_more_done", extra, 0);
    check("drop_idle_ch_sel", bad, 0);
    check("drop_status_kept", status_out, 32'h6666_6666);

    // Reset during SETTLE of ch4 abandons the scan; restart at ch0.
    ok_pat = 4'h2;
    flt_pat = 4'h3;
    flt_mask = 8'h01;
    settle_cycles = 8'd2;
    enable = 1'b1;
    wait_ch("rst_mid_ch4", 3'd4);
    check("rst_mid_fault_pre", fault_sticky, 8'h01);
    ARESETN = 1'b0;
    #1;
    check("rst_mid_ch_sel", ch_sel, 0);
    check("rst_mid_status", status_out, 0);
    check("rst_mid_fault", fault_sticky, 0);
    check("rst_mid_irq", irq, 0);
    check("rst_mid_done", scan_done, 0);
    check("rst_mid_ready", clr_ready, 1);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    check("rst_rel_ch_sel", ch_sel, 0);
    cnt = 0;
    extra = 0;
    do begin
      @(negedge ACLK);
      cnt++;
      if (scan_done) extra++;
    end while (ch_sel != 3'd1 && cnt < LIMIT);
    check("rst_rel_ch1_at", cnt, 6);
    check("rst_rel_no_done", extra, 0);
    check("rst_rel_fault", fault_sticky, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_status_scanner.md
INV_STATUS_SCANNER -- requirements
Module: inv_status_scanner

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of inverter channels scanned (2..16).
REQ-002 SHALL have parameter STATUS_W, default 4: status bits per channel; bit 0 = fault, bit 1 = ready, others = user.
REQ-003 SHALL have port ACLK, in, 1: single clock for all logic.
REQ-004 SHALL have port ARESETN, in, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, in, 1: continuous scanning enabled.
REQ-006 SHALL have port settle_cycles, in, 8: mux settle wait, in cycles, per channel.
REQ-007 SHALL have port ch_sel, out, $clog2(N_CH): select driven to the status mux.
REQ-008 SHALL have port status_in, in, STATUS_W: muxed status of the selected channel.
REQ-009 SHALL have port status_out, out, N_CH*STATUS_W: last sampled snapshot per channel; channel k is at [k*STATUS_W +: STATUS_W].
REQ-010 SHALL have port fault_sticky, out, N_CH: latched fault per channel.
REQ-011 SHALL have port clr_valid, in, 1: clear request.
REQ-012 SHALL have port clr_mask, in, N_CH: channels to clear.
REQ-013 SHALL have port clr_ready, out, 1: clear accepted when clr_valid & clr_ready.
REQ-014 SHALL have port scan_done, out, 1: one-cycle pulse at the end of each full scan.
REQ-015 SHALL have port irq, out, 1: registered OR of fault_sticky.

Function
REQ-016 SHALL implement the FSM states IDLE, SETTLE, SAMPLE and ADVANCE.
REQ-017 IDLE: ch_sel=0; when enable=1, SHALL load the settle counter with settle_cycles and go to SETTLE on the next cycle.
REQ-018 SETTLE: SHALL decrement the counter each cycle and go to SAMPLE in the cycle after the counter reads 0; settle_cycles=0 SHALL give exactly one SETTLE cycle.
REQ-019 SAMPLE: SHALL write status_in to status_out[ch_sel]; if status_in[0]=1, SHALL set fault_sticky[ch_sel]; then SHALL go to ADVANCE.
REQ-020 ADVANCE, ch_sel<N_CH-1: SHALL increment ch_sel, reload the counter and go to SETTLE.
REQ-021 ADVANCE, ch_sel=N_CH-1: SHALL set ch_sel=0 and pulse scan_done for one cycle; SHALL go to SETTLE (reloaded) if enable=1, else to IDLE.
REQ-022 Per-channel period SHALL be settle_cycles+3 cycles; full scan period SHALL be N_CH*(settle_cycles+3) cycles.
REQ-023 enable deasserted mid-scan SHALL let the current scan complete, including scan_done, before entering IDLE.
REQ-024 settle_cycles SHALL be sampled only at counter load; changes mid-SETTLE take effect on the next channel.
REQ-025 clr_ready SHALL be 1 in all states except SAMPLE.
REQ-026 On handshake, fault_sticky bits in clr_mask SHALL clear on the next edge.
REQ-027 A fault set and a clear of the same bit in the same cycle cannot collide, because of REQ-025; set SHALL have priority if the design is ever changed so they can.
REQ-028 irq SHALL lag fault_sticky by exactly one cycle.
REQ-029 ch_sel SHALL change only on ADVANCE→SETTLE or ADVANCE→IDLE transitions.
REQ-030 status_out SHALL retain its values while in IDLE.

Reset
REQ-031 ARESETN=0 SHALL asynchronously force: state=IDLE, ch_sel=0, counter=0, status_out=0, fault_sticky=0, scan_done=0, irq=0.
REQ-032 clr_ready SHALL be 1 during and after reset.
REQ-033 Reset mid-scan SHALL abandon the scan; no scan_done pulse is produced.
REQ-034 After reset release, scanning SHALL restart from channel 0.

Structure
REQ-035 Package inv_status_pkg SHALL hold the state enum, the FAULT_BIT and READY_BIT indices, and the defaults for N_CH and STATUS_W.
REQ-036 The settle down-counter SHALL be a sub-module named inv_status_settle_timer, with ports load, value, and expired.
REQ-037 Target RTL size SHALL be 150-300 lines.

Verification
REQ-038 Scenario: N_CH=8, settle_cycles=2, enable=1, constant status_in=4'b0010 -> ch_sel steps 0..7 every 5 cycles; scan_done pulses every 40 cycles; all status_out nibbles = 2; fault_sticky=0; irq=0.
REQ-039 Scenario: status_in[0]=1 only while ch_sel=5 -> fault_sticky=8'h20; irq=1 one cycle after the set; the bit stays set after status_in returns to 0.
REQ-040 Scenario: fault_sticky=8'h21, clr_valid=1 with clr_mask=8'h01 outside SAMPLE -> fault_sticky=8'h20 next cycle; irq stays 1; clearing mask 8'h20 as well -> irq=0 one cycle later.
REQ-041 Scenario: clr_valid held high during SAMPLE of the faulting channel -> clr_ready=0 that cycle; the clear completes next cycle, after the set, leaving the bit at 0.
REQ-042 Scenario: settle_cycles=0, then enable dropped at ch_sel=3 -> 3-cycle channel period; scan finishes through ch 7; scan_done pulses once; FSM goes to IDLE with ch_sel=0.
REQ-043 Scenario: ARESETN pulsed low during SETTLE at ch_sel=4 -> all outputs reset immediately; no scan_done; after release, the scan resumes at ch 0.
